// File: rtl/tanh_neuron_serializer.sv
// Captures the activated-neuron vector on Start and streams it one word per
// valid/ready transfer, tagging each word with its index and a last flag.
module tanh_neuron_serializer #(
  parameter int DataWidth     = 32,
  parameter int No_of_Neurons = 24,
  parameter int CountWidth    = 5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               Start,
  input  logic [DataWidth*No_of_Neurons-1:0] ActivatedNeurons,
  output logic                               Busy,
  output logic [DataWidth-1:0]               OutData,
  output logic                               OutValid,
  input  logic                               OutReady,
  output logic [CountWidth-1:0]              OutIndex,
  output logic                               OutLast,
  output logic                               Finished
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]                         state_p1;
  logic [DataWidth*No_of_Neurons-1:0] buf_p0;
  logic [DataWidth-1:0]               data_p1;
  logic [DataWidth-1:0]               next_word;
  logic [CountWidth-1:0]              idx_p1;
  logic                               vld_p1;
  logic                               last_p1;
  logic                               fin_p1;
  logic                               busy_p1;
  logic                               capture;
  logic                               xfer;
  int                                 next_pos;

  assign capture = (state_p1 == S_IDLE) && Start;
  assign xfer    = (state_p1 == S_STREAM) && vld_p1 && OutReady;

  // Word that follows the one currently presented; only meaningful before the last word.
  always_comb begin
    next_pos  = int'(idx_p1) + 1;
    next_word = '0;
    if (next_pos < No_of_Neurons)
      next_word = buf_p0[next_pos*DataWidth +: DataWidth];
  end

  // Stage p0: capture buffer, data only, not reset
  always_ff @(posedge clk) begin
    if (capture)
      buf_p0 <= ActivatedNeurons;
  end

  // Stage p1: registered stream outputs and control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1 <= S_IDLE;
      data_p1  <= '0;
      idx_p1   <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      fin_p1   <= 1'b0;
      busy_p1  <= 1'b0;
    end else begin
      unique case (state_p1)
        S_IDLE: begin
          fin_p1 <= 1'b0;
          if (capture) begin
            state_p1 <= S_STREAM;
            data_p1  <= ActivatedNeurons[DataWidth-1:0];
            idx_p1   <= '0;
            vld_p1   <= 1'b1;
            last_p1  <= (No_of_Neurons == 1);
            busy_p1  <= 1'b1;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            if (last_p1) begin
              state_p1 <= S_DONE;
              vld_p1   <= 1'b0;
              last_p1  <= 1'b0;
              fin_p1   <= 1'b1;
            end else begin
              idx_p1  <= idx_p1 + CountWidth'(1);
              data_p1 <= next_word;
              last_p1 <= (next_pos == No_of_Neurons - 1);
            end
          end
        end
        S_DONE: begin
          state_p1 <= S_IDLE;
          fin_p1   <= 1'b0;
          busy_p1  <= 1'b0;
        end
        default: begin
          state_p1 <= S_IDLE;
          vld_p1   <= 1'b0;
          last_p1  <= 1'b0;
          fin_p1   <= 1'b0;
          busy_p1  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy     = busy_p1;
  assign OutData  = data_p1;
  assign OutValid = vld_p1;
  assign OutIndex = idx_p1;
  assign OutLast  = last_p1;
  assign Finished = fin_p1;

endmodule

// File: tb/tb_tanh_neuron_serializer.sv
// Randomized bench for tanh_neuron_serializer against a queue-based stream model.
module tb_tanh_neuron_serializer;

  localparam int DW = 32;
  localparam int NN = 24;
  localparam int CW = 5;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               ready = 1'b0;
  logic [DW*NN-1:0]   vec = '0;
  logic               busy, ovalid, olast, fin;
  logic [DW-1:0]      odata;
  logic [CW-1:0]      oidx;

  logic               start1 = 1'b0;
  logic               ready1 = 1'b0;
  logic [DW-1:0]      vec1 = 32'hFFFF_0001;
  logic               busy1, ovalid1, olast1, fin1;
  logic [DW-1:0]      odata1;
  logic [0:0]         oidx1;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of words still to be delivered plus a finish flag.
  logic [DW-1:0] mq[$];
  int            m_idx = 0;
  bit            m_fin = 1'b0;
  int            fin_seen = 0;
  int            fin_exp = 0;
  int            pat[6] = '{1, 0, 0, 1, 0, 1};

  always #5 clk = ~clk;

  tanh_neuron_serializer #(.DataWidth(DW), .No_of_Neurons(NN), .CountWidth(CW)) dut (
    .clk(clk), .reset(reset), .Start(start), .ActivatedNeurons(vec),
    .Busy(busy), .OutData(odata), .OutValid(ovalid), .OutReady(ready),
    .OutIndex(oidx), .OutLast(olast), .Finished(fin)
  );

  tanh_neuron_serializer #(.DataWidth(DW), .No_of_Neurons(1), .CountWidth(1)) dut1 (
    .clk(clk), .reset(reset), .Start(start1), .ActivatedNeurons(vec1),
    .Busy(busy1), .OutData(odata1), .OutValid(ovalid1), .OutReady(ready1),
    .OutIndex(oidx1), .OutLast(olast1), .Finished(fin1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return (mq.size() != 0) || m_fin;
  endfunction

  task automatic model_edge();
    logic [DW-1:0] tmp;
    if (reset) begin
      mq.delete();
      m_idx = 0;
      m_fin = 1'b0;
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (mq.size() == 0) begin
      if (start) begin
        for (int i = 0; i < NN; i++) mq.push_back(vec[i*DW +: DW]);
        m_idx = 0;
      end
    end else if (ready) begin
      tmp = mq.pop_front();
      m_idx++;
      if (mq.size() == 0) begin
        m_fin = 1'b1;
        fin_exp++;
      end
    end
  endtask

  task automatic compare();
    check_eq("valid", 32'(ovalid), 32'(mq.size() != 0));
    check_eq("busy", 32'(busy), 32'(m_busy()));
    check_eq("finished", 32'(fin), 32'(m_fin));
    if (mq.size() != 0) begin
      check_eq("data", odata, mq[0]);
      check_eq("index", 32'(oidx), 32'(m_idx));
      check_eq("last", 32'(olast), 32'(mq.size() == 1));
    end else begin
      check_eq("last_idle", 32'(olast), 32'd0);
    end
    if (fin) fin_seen++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic fill_seq(input logic [31:0] base);
    for (int i = 0; i < NN; i++) vec[i*DW +: DW] = base + 32'(i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NN; i++) vec[i*DW +: DW] = $urandom;
  endtask

  // mode 0: ready high; 1: fixed stall pattern; 2: random; 3: ready high, Start poked at index 5
  task automatic stream(input int mode, input int budget);
    int k = 0;
    while (m_busy() && k < budget) begin
      case (mode)
        1:       ready = pat[k % 6][0];
        2:       ready = 1'($urandom_range(0, 1));
        default: ready = 1'b1;
      endcase
      start = (mode == 3) && (m_idx == 5);
      cycle();
      if (mode == 3 && k == 0) begin
        for (int i = 0; i < NN; i++) vec[i*DW +: DW] = 32'hDEAD_BEEF;
      end
      k++;
    end
    start = 1'b0;
    check_eq("drain_in_budget", 32'(k < budget), 32'd1);
  endtask

  task automatic launch();
    start = 1'b1;
    ready = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    int fin_base;
    reset = 1'b1;
    #3;
    check_eq("rst_valid", 32'(ovalid), 32'd0);
    check_eq("rst_data", odata, 32'd0);
    check_eq("rst_index", 32'(oidx), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_fin", 32'(fin), 32'd0);
    cycle();
    cycle();
    #3 reset = 1'b0;

    // Full-rate stream of the sequential vector
    fill_seq(32'h1000_0000);
    launch();
    stream(0, 100);
    cycle();
    cycle();

    // Fixed backpressure pattern
    launch();
    stream(1, 200);
    cycle();

    // Capture isolation and Start ignored while busy
    fill_seq(32'h1000_0000);
    launch();
    stream(3, 100);
    cycle();

    // Async reset after ten transfers, asserted between edges
    fill_rand();
    launch();
    for (int i = 0; i < 10; i++) cycle();
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(ovalid), 32'd0);
    check_eq("mid_rst_data", odata, 32'd0);
    check_eq("mid_rst_index", 32'(oidx), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    cycle();
    #3 reset = 1'b0;
    fill_rand();
    launch();
    stream(2, 400);
    cycle();

    // Start held high: recapture on the first IDLE edge after DONE
    fill_seq(32'h2000_0000);
    fin_base = fin_seen;
    start = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 53; i++) cycle();
    check_eq("fin_per_stream", 32'(fin_seen - fin_base), 32'd2);
    start = 1'b0;
    stream(0, 100);
    cycle();

    // Randomized streams
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      launch();
      stream(2, 400);
      cycle();
    end
    check_eq("fin_count", 32'(fin_seen), 32'(fin_exp));

    // Single-neuron instance
    start1 = 1'b1;
    ready1 = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b0;
    check_eq("n1_valid", 32'(ovalid1), 32'd1);
    check_eq("n1_last", 32'(olast1), 32'd1);
    check_eq("n1_data", odata1, 32'hFFFF_0001);
    check_eq("n1_index", 32'(oidx1), 32'd0);
    check_eq("n1_busy", 32'(busy1), 32'd1);
    @(posedge clk); #1;
    check_eq("n1_hold_valid", 32'(ovalid1), 32'd1);
    check_eq("n1_hold_fin", 32'(fin1), 32'd0);
    ready1 = 1'b1;
    @(posedge clk); #1;
    ready1 = 1'b0;
    check_eq("n1_done_valid", 32'(ovalid1), 32'd0);
    check_eq("n1_done_last", 32'(olast1), 32'd0);
    check_eq("n1_done_fin", 32'(fin1), 32'd1);
    check_eq("n1_done_busy", 32'(busy1), 32'd1);
    @(posedge clk); #1;
    check_eq("n1_idle_fin", 32'(fin1), 32'd0);
    check_eq("n1_idle_busy", 32'(busy1), 32'd0);
    check_eq("n1_idle_valid", 32'(ovalid1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
